// File: rtl/tt_scan_collector.sv
// rtl/tt_scan_collector.sv - enumerates 128 patterns on x and captures f_in into a truth table
// Optional ones counter enabled by defining TT_POPCOUNT_EN; otherwise ones_count is tied to 0.
module tt_scan_collector #(
    parameter int unsigned SETTLE = 0,
    parameter int unsigned N_PAT  = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [6:0]   x,
    input  logic         f_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] tt,
    output logic [7:0]   ones_count
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam logic [3:0] SETTLE_W = 4'(SETTLE);
    localparam logic [6:0] LAST_IDX = 7'(N_PAT - 1);

    state_t       state_q, state_d;
    logic [6:0]   idx_q, idx_d;
    logic [3:0]   wait_q, wait_d;
    logic [127:0] tt_q, tt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            tt_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            tt_q    <= tt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        tt_d    = tt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                    wait_d  = SETTLE_W;
                    tt_d    = '0;
                end
            end
            S_SCAN: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    tt_d[idx_q] = f_in;
                    // Termination is decided before incrementing so idx never wraps inside a scan.
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d  = idx_q + 7'd1;
                        wait_d = SETTLE_W;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // x follows idx directly: 0 after reset/start, holds the last pattern in DONE.
    assign x    = idx_q;
    assign busy = (state_q == S_SCAN);
    assign done = (state_q == S_DONE);
    assign tt   = tt_q;

`ifdef TT_POPCOUNT_EN
    logic [7:0] cnt_q;
    logic       clear;
    logic       capture;

    assign clear   = (state_q != S_SCAN) && start;
    assign capture = (state_q == S_SCAN) && (wait_q == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (capture && f_in) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign ones_count = cnt_q;
`else
    assign ones_count = 8'd0;
`endif

endmodule

// File: tb/tb_tt_scan_collector.sv
// tb/tb_tt_scan_collector.sv - randomized self-checking bench for tt_scan_collector (SETTLE 0 and 3)
module tb_tt_scan_collector;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]   start_v;
    logic [1:0]   f_v;
    logic [1:0]   busy_v;
    logic [1:0]   done_v;
    logic [6:0]   x_v  [2];
    logic [127:0] tt_v [2];
    logic [7:0]   oc_v [2];
    int           fsel_v [2];
    logic [127:0] rtab;

    int n_tests = 0;
    int n_fail  = 0;

    // 0: x0, 1: AND of all, 2: majority(x0,x1,x2), 3: constant 1, else: random lookup table
    function automatic logic fn(input int sel, input logic [6:0] xi, input logic [127:0] tab);
        case (sel)
            0:       return xi[0];
            1:       return &xi;
            2:       return (xi[0] & xi[1]) | (xi[0] & xi[2]) | (xi[1] & xi[2]);
            3:       return 1'b1;
            default: return tab[xi];
        endcase
    endfunction

    always_comb begin
        f_v    = '0;
        f_v[0] = fn(fsel_v[0], x_v[0], rtab);
        f_v[1] = fn(fsel_v[1], x_v[1], rtab);
    end

    tt_scan_collector #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .x(x_v[0]), .f_in(f_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .tt(tt_v[0]), .ones_count(oc_v[0])
    );

    tt_scan_collector #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .x(x_v[1]), .f_in(f_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .tt(tt_v[1]), .ones_count(oc_v[1])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_tt(input int sel, input logic [127:0] tab);
        logic [127:0] t = '0;
        for (int i = 0; i < 128; i++) t[i] = fn(sel, 7'(i), tab);
        return t;
    endfunction

    function automatic logic [7:0] model_oc(input logic [127:0] t);
        int n = 0;
`ifdef TT_POPCOUNT_EN
        for (int i = 0; i < 128; i++) n += int'(t[i]);
`endif
        return 8'(n);
    endfunction

    // Starts a scan on instance w and follows it to completion; w=0 has SETTLE 0, w=1 has SETTLE 3.
    task automatic run_scan(input int w, input int sel, input bit pulse, input bit hold);
        int s = (w == 0) ? 0 : 3;
        int cyc = 0;
        logic [127:0] exp_tt;
        fsel_v[w] = sel;
        exp_tt = model_tt(sel, rtab);
        @(negedge clk);
        start_v[w] = 1'b1;
        @(negedge clk);
        start_v[w] = hold;
        check("clear_tt", tt_v[w], '0);
        check("clear_oc", 128'(oc_v[w]), '0);
        while (busy_v[w] && cyc < 2000) begin
            check("x_seq", 128'(x_v[w]), 128'(cyc / (s + 1)));
            cyc++;
            start_v[w] = hold || (pulse && (cyc == 10 || cyc == 60));
            @(negedge clk);
        end
        check("busy_len", 128'(cyc), 128'(128 * (s + 1)));
        check("done", 128'(done_v[w]), 128'(1));
        check("tt", tt_v[w], exp_tt);
        check("ones", 128'(oc_v[w]), 128'(model_oc(exp_tt)));
        check("x_hold", 128'(x_v[w]), 128'(127));
    endtask

    initial begin
        rst       = 1'b1;
        start_v   = '0;
        fsel_v[0] = 0;
        fsel_v[1] = 0;
        rtab      = '0;
        #1;
        check("rst_busy", 128'(busy_v), '0);
        check("rst_done", 128'(done_v), '0);
        check("rst_x", 128'(x_v[0]), '0);
        check("rst_tt", tt_v[0], '0);
        check("rst_oc", 128'(oc_v[0]), '0);
        @(negedge clk);
        rst = 1'b0;

        run_scan(0, 0, 1'b0, 1'b0);
        check("tt_x0_const", tt_v[0], {4{32'hAAAA_AAAA}});
        run_scan(1, 1, 1'b0, 1'b0);
        check("tt_and_const", tt_v[1], {32'h8000_0000, 96'h0});
        run_scan(0, 2, 1'b0, 1'b0);
        check("tt_maj_const", tt_v[0], {4{32'hE8E8_E8E8}});
        run_scan(0, 3, 1'b0, 1'b0);
        check("tt_ones_const", tt_v[0], {128{1'b1}});
        repeat (5) @(negedge clk);
        check("done_stable", 128'(done_v[0]), 128'(1));
        check("tt_stable", tt_v[0], {128{1'b1}});
        run_scan(0, 0, 1'b0, 1'b0);

        // Reset at cycle 40 of a scan
        fsel_v[0] = 3;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (39) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 128'(busy_v[0]), '0);
        check("mid_rst_x", 128'(x_v[0]), '0);
        check("mid_rst_tt", tt_v[0], '0);
        check("mid_rst_done", 128'(done_v[0]), '0);
        @(negedge clk);
        rst = 1'b0;
        run_scan(0, 2, 1'b0, 1'b0);

        run_scan(0, 0, 1'b1, 1'b0);
        run_scan(1, 2, 1'b1, 1'b0);

        // Start held high: done lasts one cycle, then a new scan begins
        run_scan(0, 3, 1'b0, 1'b1);
        @(negedge clk);
        check("hold_busy", 128'(busy_v[0]), 128'(1));
        check("hold_done", 128'(done_v[0]), '0);
        start_v[0] = 1'b0;
        for (int k = 0; k < 300 && !done_v[0]; k++) @(negedge clk);
        check("hold_redone", 128'(done_v[0]), 128'(1));
        check("hold_tt", tt_v[0], {128{1'b1}});

        for (int r = 0; r < 4; r++) begin
            rtab = {$urandom, $urandom, $urandom, $urandom};
            run_scan(r % 2, 4, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
